// File: rtl/sub_pkg.sv
// Shared definitions for the sequential slice-serial subtractor.
package sub_pkg;

  localparam int unsigned WIDTH_DEF  = 32'd32;
  localparam int unsigned SLICE_DEF  = 32'd8;
  localparam int unsigned NUM_SLICES = WIDTH_DEF / SLICE_DEF;
  localparam int unsigned IDX_W      = (NUM_SLICES > 32'd1) ? $clog2(NUM_SLICES) : 32'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/byte_sub_stage.sv
// One combinational slice of the subtractor: diff = a + ~b + ~bin.
// bin/bout use borrow polarity (1 = borrow), the inverse of an adder carry.
module byte_sub_stage #(
  parameter int unsigned SLICE = 32'd8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] diff,
  output logic             bout
);

  logic [SLICE:0] sum_s;

  // Add the minuend to the one's complement of the subtrahend plus inverted borrow.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, ~b} + {{SLICE{1'b0}}, ~bin};
    diff  = sum_s[SLICE-1:0];
    bout  = ~sum_s[SLICE];
  end

endmodule

// File: rtl/seq_subtractor_32bit.sv
// Slice-serial subtractor: DIFF = A - B - bin, one SLICE-bit slice per clock,
// LSB slice first, with a registered borrow between slices. Valid/ready on
// both sides; results and flags are held until the next completed operation.
import sub_pkg::*;

module seq_subtractor_32bit #(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned SLICE = SLICE_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             bin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] DIFF_o,
  output logic             bout_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned NSL = WIDTH / SLICE;
  localparam int unsigned IW  = (NSL > 32'd1) ? $clog2(NSL) : 32'd1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSL - 32'd1);

  sub_state_e       state_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [31:0]      bit_base_s;
  logic [SLICE-1:0] slice_a_s;
  logic [SLICE-1:0] slice_b_s;
  logic [SLICE-1:0] slice_diff_s;
  logic             slice_bout_s;
  logic [WIDTH-1:0] final_diff_s;
  logic             final_ovf_s;
  logic             final_zero_s;

  // Select the operand slice addressed by the current slice index.
  always_comb begin
    bit_base_s = 32'(idx_r) * SLICE;
    slice_a_s  = a_r[bit_base_s +: SLICE];
    slice_b_s  = b_r[bit_base_s +: SLICE];
  end

  byte_sub_stage #(
    .SLICE (SLICE)
  ) u_stage (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .bin  (borrow_r),
    .diff (slice_diff_s),
    .bout (slice_bout_s)
  );

  // Full result as it will look once the top slice (being computed now) lands.
  always_comb begin
    final_diff_s                  = acc_r;
    final_diff_s[WIDTH-1 -: SLICE] = slice_diff_s;
    final_ovf_s  = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (final_diff_s[WIDTH-1] != a_r[WIDTH-1]);
    final_zero_s = ~|final_diff_s;
  end

  // Control FSM, operand capture, slice accumulation and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      borrow_r    <= 1'b0;
      acc_r       <= '0;
      diff_r      <= '0;
      bout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid_i && in_ready_r) begin
            a_r        <= A_i;
            b_r        <= B_i;
            borrow_r   <= bin_i;
            idx_r      <= '0;
            acc_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= BUSY;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        BUSY: begin
          acc_r[bit_base_s +: SLICE] <= slice_diff_s;
          borrow_r                   <= slice_bout_s;
          idx_r                      <= idx_r + IW'(1);
          if (idx_r == LAST_IDX) begin
            diff_r      <= final_diff_s;
            bout_r      <= slice_bout_s;
            ovf_r       <= final_ovf_s;
            zero_r      <= final_zero_s;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r     <= BUSY;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign DIFF_o      = diff_r;
  assign bout_o      = bout_r;
  assign ovf_o       = ovf_r;
  assign zero_o      = zero_r;

endmodule

// File: tb/tb_seq_subtractor_32bit.sv
// Scoreboard bench for seq_subtractor_32bit: directed vectors plus random
// regression with output stalls, checked against a plain-arithmetic model.
module tb_seq_subtractor_32bit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        bin_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] DIFF_o;
  logic        bout_o;
  logic        ovf_o;
  logic        zero_o;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          rdy_rand = 1'b0;
  logic        rdy_fixed = 1'b1;
  logic        prev_v = 1'b0;
  bit          hold = 1'b0;
  logic [34:0] held = '0;

  seq_subtractor_32bit dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .A_i         (A_i),
    .B_i         (B_i),
    .bin_i       (bin_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .DIFF_o      (DIFF_o),
    .bout_o      (bout_o),
    .ovf_o       (ovf_o),
    .zero_o      (zero_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: 33-bit unsigned difference for DIFF/borrow, wide signed math for overflow.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    exp_t        e;
    logic [32:0] r;
    longint      s;
    r    = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    s    = longint'($signed(a)) - longint'($signed(b)) - longint'({31'd0, bi});
    e.d  = r[31:0];
    e.bo = r[32];
    e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    e.z  = (r[31:0] == 32'd0);
    e.acc = 0;
    return e;
  endfunction

  // Monitor: samples mid-cycle, after the driver has settled the inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (!rst_ni) begin
        q.delete();
        prev_v = 1'b0;
        hold   = 1'b0;
      end else begin
        if (out_valid_o && !prev_v) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid: got out_valid=1 required no pending op");
          end else begin
            chk("latency", 64'(cyc), 64'(q[0].acc + 4));
          end
        end
        if (hold && out_valid_o)
          chk("stall_stable", {29'd0, DIFF_o, bout_o, ovf_o, zero_o}, {29'd0, held});
        hold = out_valid_o && !out_ready_i;
        held = {DIFF_o, bout_o, ovf_o, zero_o};
        if (out_valid_o && out_ready_i) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got DIFF=%0h required no output", DIFF_o);
          end else begin
            e = q.pop_front();
            chk("diff", 64'(DIFF_o), 64'(e.d));
            chk("bout", 64'(bout_o), 64'(e.bo));
            chk("ovf",  64'(ovf_o),  64'(e.ov));
            chk("zero", 64'(zero_o), 64'(e.z));
          end
        end
        if (in_valid_i && in_ready_o) begin
          e     = model(A_i, B_i, bin_i);
          e.acc = cyc + 1;
          q.push_back(e);
        end
        prev_v = out_valid_o;
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    out_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bi);
    int t = 0;
    tick();
    A_i = a; B_i = b; bin_i = bi; in_valid_i = 1'b1;
    #1;
    while (!in_ready_o && t < 100) begin
      tick(); #1; t++;
    end
    if (!in_ready_o) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 required 1 within 100 cycles");
    end
    @(posedge clk_i);
    tick();
    in_valid_i = 1'b0;
    A_i = $urandom(); B_i = $urandom(); bin_i = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || out_valid_o) && t < 200) begin
      tick(); #1; t++;
    end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending required 0", q.size());
    end
  endtask

  task automatic last(input logic [31:0] d, input logic bo, input logic ov, input logic z);
    chk("held_diff", 64'(DIFF_o), 64'(d));
    chk("held_bout", 64'(bout_o), 64'(bo));
    chk("held_ovf",  64'(ovf_o),  64'(ov));
    chk("held_zero", 64'(zero_o), 64'(z));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int t;
    rst_ni = 1'b0; in_valid_i = 1'b0; A_i = '0; B_i = '0; bin_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_in_ready",  64'(in_ready_o),  64'd0);
    last(32'h0, 1'b0, 1'b0, 1'b0);
    tick(); rst_ni = 1'b1;
    tick(); #1;
    chk("ready_after_rst", 64'(in_ready_o), 64'd1);

    // Basic, cross-slice borrow, wrap, overflow, borrow-in to zero.
    send(32'h0000_0005, 32'h0000_0003, 1'b0); drain(); last(32'h0000_0002, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0100, 32'h0000_0001, 1'b0); drain(); last(32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0000, 32'h0000_0001, 1'b0); drain(); last(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0); drain(); last(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send(32'h1234_5678, 32'h1234_5677, 1'b1); drain(); last(32'h0000_0000, 1'b0, 1'b0, 1'b1);

    // Backpressure with new operands pending and A_i toggling.
    rdy_fixed = 1'b0;
    send(32'h0000_1000, 32'h0000_0001, 1'b0);
    t = 0;
    while (!out_valid_o && t < 50) begin tick(); #1; t++; end
    chk("bp_valid", 64'(out_valid_o), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      in_valid_i = 1'b1; A_i = ~A_i; B_i = $urandom(); bin_i = ~bin_i;
      #1;
      chk("bp_in_ready", 64'(in_ready_o), 64'd0);
      chk("bp_diff", {31'd0, DIFF_o, bout_o}, {31'd0, 32'h0000_0FFF, 1'b0});
    end
    rdy_fixed = 1'b1;
    send(32'h0000_0020, 32'h0000_0030, 1'b0); drain(); last(32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);

    // Reset while the third slice is being processed.
    send(32'hDEAD_0000, 32'h0000_0001, 1'b0);
    tick(); tick();
    rst_ni = 1'b0;
    tick(); rst_ni = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
    chk("mid_rst_ready", 64'(in_ready_o),  64'd0);
    last(32'h0, 1'b0, 1'b0, 1'b0);
    tick(); #1;
    chk("mid_rst_ready_rel", 64'(in_ready_o), 64'd1);
    send(32'h0000_0007, 32'h0000_0002, 1'b0); drain(); last(32'h0000_0005, 1'b0, 1'b0, 1'b0);

    // Random regression with output stalls.
    rdy_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      send(pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
